// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU issue stage: supported opcodes, the issue
// FSM state encoding, the register-form instruction layout and the opcode
// legality check.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  localparam int INSTR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // {OPCODE[9:6], RD[5:4], RA[3:2], RB[1:0]}
  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

  // True for the six opcodes this stage can hand to the ALU.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal_s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: legal_s = 1'b1;
      default:                                       legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// ----------------------------------------------------------------------------
// alu_regfile
// NREGS x WIDTH register file for the ALU issue stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear
//   wb_en/addr/data       write-back port (wins over the host port on a clash)
//   host_we/addr/data     host preload port
//   ra_addr/ra_data       operand A read (combinational)
//   rb_addr/rb_data       operand B read (combinational)
//   rd_addr/rd_data       host readback (combinational)
// ----------------------------------------------------------------------------
module alu_regfile
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] regs_r [NREGS];

  // Register storage: write-back takes a register outright; a host write to
  // that same register in the same cycle is dropped, other registers still
  // accept the host write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          regs_r[i] <= wb_data;
        end else if (host_we && (host_addr == AW'(i))) begin
          regs_r[i] <= host_data;
        end
      end
    end
  end

  assign ra_data = regs_r[ra_addr];
  assign rb_data = regs_r[rb_addr];
  assign rd_data = regs_r[rd_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue stage in front of the parameterised ALU. Accepts 10-bit register-form
// instructions over valid/ready, reads operands from a local register file,
// drives the ALU, waits ALU_LAT cycles and writes the result and flags back.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready   instruction handshake (ready only in IDLE)
//   wr_en/wr_addr/wr_data           host register write (any state)
//   rd_addr/rd_data                 host combinational readback
//   alu_en/alu_oe/alu_opcode/alu_a/alu_b   ALU drive (all registered)
//   alu_out, cf, of, sf, zf         ALU result and flags
//   flags                           {CF,OF,SF,ZF} of the last retired op
//   done, illegal                   one-cycle status pulses
//   busy                            inverse of instr_ready
//   trap                            (OVF_TRAP_EN only) overflow-trap pulse
// Configuration macro: OVF_TRAP_EN -- ADD/SUB retiring with OF=1 skip the
// register write; flags still update and trap pulses alongside done.
// ----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NREGS   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [9:0]       instr,
  output logic             instr_ready,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             alu_en,
  output logic             alu_oe,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             cf,
  input  logic             of,
  input  logic             sf,
  input  logic             zf,
  output logic [3:0]       flags,
`ifdef OVF_TRAP_EN
  output logic             trap,
`endif
  output logic             done,
  output logic             illegal,
  output logic             busy
);

  localparam int AW    = 2;
  localparam int CNT_W = 2;

  instr_t           instr_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             legal_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       rd_r;
  logic [WIDTH-1:0] ra_data_s;
  logic [WIDTH-1:0] rb_data_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic             wb_en_s;
  logic             trap_hit_s;

  logic             alu_en_r;
  logic             alu_oe_r;
  logic [3:0]       alu_opcode_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [3:0]       flags_r;
  logic             done_r;
  logic             illegal_r;
`ifdef OVF_TRAP_EN
  logic             trap_r;
`endif

  assign instr_s     = instr_t'(instr);
  assign instr_ready = (state_r == ST_IDLE);
  assign busy        = ~instr_ready;
  assign accept_s    = instr_valid & instr_ready;
  assign legal_s     = is_legal_op(instr_s.opcode);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_en     (wb_en_s),
    .wb_addr   (rd_r),
    .wb_data   (alu_out),
    .host_we   (wr_en),
    .host_addr (wr_addr),
    .host_data (wr_data),
    .ra_addr   (instr_s.ra),
    .ra_data   (ra_data_s),
    .rb_addr   (instr_s.rb),
    .rb_data   (rb_data_s),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Operand capture happens on the accept edge, but the ALU must see the
  // register contents of the ISSUE cycle, so a host write landing on that
  // same edge is forwarded. NOT ignores RB and drives B to zero.
  always_comb begin
    opa_s = ra_data_s;
    opb_s = rb_data_s;
    if (wr_en && (wr_addr == instr_s.ra)) begin
      opa_s = wr_data;
    end else begin
      opa_s = ra_data_s;
    end
    if (instr_s.opcode == OP_NOT) begin
      opb_s = {WIDTH{1'b0}};
    end else if (wr_en && (wr_addr == instr_s.rb)) begin
      opb_s = wr_data;
    end else begin
      opb_s = rb_data_s;
    end
  end

  // Write-back enable, optionally suppressed by an overflow trap.
  always_comb begin
    trap_hit_s = 1'b0;
    wb_en_s    = 1'b0;
`ifdef OVF_TRAP_EN
    if ((state_r == ST_WB) && of &&
        ((alu_opcode_r == OP_ADD) || (alu_opcode_r == OP_SUB))) begin
      trap_hit_s = 1'b1;
    end else begin
      trap_hit_s = 1'b0;
    end
`endif
    if ((state_r == ST_WB) && !trap_hit_s) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: illegal opcodes are consumed without leaving IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && legal_s) begin
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nx_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_nx_s = ST_WB;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_WB:   state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Registered ALU drive, latency counter and status pulses. Outputs are set
  // one edge ahead of the state they belong to so every port is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= 2'd0;
      rd_r         <= 2'd0;
      alu_en_r     <= 1'b0;
      alu_oe_r     <= 1'b0;
      alu_opcode_r <= 4'd0;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      flags_r      <= 4'd0;
      done_r       <= 1'b0;
      illegal_r    <= 1'b0;
`ifdef OVF_TRAP_EN
      trap_r       <= 1'b0;
`endif
    end else begin
      alu_en_r  <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
`ifdef OVF_TRAP_EN
      trap_r    <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (accept_s && legal_s) begin
            alu_en_r     <= 1'b1;
            alu_oe_r     <= 1'b1;
            alu_opcode_r <= instr_s.opcode;
            alu_a_r      <= opa_s;
            alu_b_r      <= opb_s;
            rd_r         <= instr_s.rd;
          end else if (accept_s) begin
            illegal_r    <= 1'b1;
          end
        end
        ST_ISSUE: begin
          cnt_r <= CNT_W'(ALU_LAT - 1);
        end
        ST_WAIT: begin
          if (cnt_r != 2'd0) begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_WB: begin
          alu_oe_r <= 1'b0;
          flags_r  <= {cf, of, sf, zf};
          done_r   <= 1'b1;
`ifdef OVF_TRAP_EN
          trap_r   <= trap_hit_s;
`endif
        end
        default: begin
          alu_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_en     = alu_en_r;
  assign alu_oe     = alu_oe_r;
  assign alu_opcode = alu_opcode_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign flags      = flags_r;
  assign done       = done_r;
  assign illegal    = illegal_r;
`ifdef OVF_TRAP_EN
  assign trap       = trap_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  localparam int WIDTH = 8;
  localparam int LAT   = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             instr_valid = 1'b0;
  logic [9:0]       instr = 10'd0;
  logic             instr_ready;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_addr = 2'd0;
  logic [7:0]       wr_data = 8'd0;
  logic [1:0]       rd_addr = 2'd0;
  logic [7:0]       rd_data;
  logic             alu_en, alu_oe;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_a, alu_b;
  logic [7:0]       alu_out = 8'd0;
  logic             cf = 1'b0, of = 1'b0, sf = 1'b0, zf = 1'b0;
  logic [3:0]       flags;
  logic             done, illegal, busy;
`ifdef OVF_TRAP_EN
  logic             trap;
`endif

  alu_issue_ctrl #(.WIDTH(WIDTH), .NREGS(4), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .alu_en(alu_en), .alu_oe(alu_oe),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .cf(cf), .of(of), .sf(sf), .zf(zf), .flags(flags),
`ifdef OVF_TRAP_EN
    .trap(trap),
`endif
    .done(done), .illegal(illegal), .busy(busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {CF,OF,SF,ZF,result}. CF is carry for ADD, borrow for SUB.
  function automatic logic [11:0] calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] wide;
    logic [7:0] r;
    logic       c, o;
    wide = 9'd0; c = 1'b0; o = 1'b0;
    case (op)
      4'b0010: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8];
                     o = (a[7] == b[7]) && (r[7] != a[7]); end
      4'b0011: begin r = a - b; c = (a < b); o = (a[7] != b[7]) && (r[7] != a[7]); end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~a;
      default: r = 8'd0;
    endcase
    return {c, o, r[7], (r == 8'd0), r};
  endfunction

  // ALU stand-in: result appears LAT cycles after alu_en is sampled.
  logic [11:0] stub_val = 12'd0;
  int          stub_cnt = 0;
  always @(posedge clk) begin
    if (alu_en) begin
      stub_val <= calc(alu_opcode, alu_a, alu_b);
      stub_cnt <= LAT;
      if (LAT == 1) {cf, of, sf, zf, alu_out} <= calc(alu_opcode, alu_a, alu_b);
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) {cf, of, sf, zf, alu_out} <= stub_val;
    end
  end

  // Behavioural model: a schedule of cycle numbers derived from the
  // latency/throughput rules, plus a plain register array.
  int         cyc = 0;
  logic [7:0] regs_m [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [3:0] flags_m = 4'd0;
  bit         busy_m = 1'b0;
  int         acc_cyc = -100, wb_cyc = -100, done_cyc = -100, ill_cyc = -100, trap_cyc = -100;
  logic [1:0] rd_m = 2'd0;
  logic [3:0] op_m = 4'd0;
  logic [7:0] a_m = 8'd0, b_m = 8'd0;
  logic [11:0] res_m = 12'd0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) regs_m[i] = 8'd0;
        flags_m = 4'd0; busy_m = 1'b0;
        acc_cyc = -100; wb_cyc = -100; done_cyc = -100; ill_cyc = -100; trap_cyc = -100;
      end else begin
        bit ready_pre, wrote;
        ready_pre = !busy_m;
        wrote = 1'b0;
        cyc++;
        if (busy_m && cyc == wb_cyc) begin
          bit trapped;
          trapped = 1'b0;
`ifdef OVF_TRAP_EN
          trapped = res_m[10] && (op_m == 4'b0010 || op_m == 4'b0011);
          if (trapped) trap_cyc = cyc;
`endif
          if (!trapped) begin regs_m[rd_m] = res_m[7:0]; wrote = 1'b1; end
          flags_m = res_m[11:8];
          done_cyc = cyc;
          busy_m = 1'b0;
        end
        if (wr_en && !(wrote && wr_addr == rd_m)) regs_m[wr_addr] = wr_data;
        if (ready_pre && instr_valid) begin
          if (instr[9:6] >= 4'd2 && instr[9:6] <= 4'd7) begin
            op_m = instr[9:6]; rd_m = instr[5:4];
            a_m = regs_m[instr[3:2]];
            b_m = (op_m == 4'b0111) ? 8'd0 : regs_m[instr[1:0]];
            res_m = calc(op_m, a_m, b_m);
            busy_m = 1'b1; acc_cyc = cyc; wb_cyc = cyc + LAT + 2;
          end else begin
            ill_cyc = cyc;
          end
        end
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  int en_cnt = 0, done_cnt = 0, ill_cnt = 0, obs_done_cyc = -1;
  initial begin
    forever begin
      @(negedge clk);
      chk("ready",   instr_ready, !busy_m);
      chk("busy",    busy, busy_m);
      chk("alu_en",  alu_en, busy_m && cyc == acc_cyc);
      chk("alu_oe",  alu_oe, busy_m);
      chk("done",    done, cyc == done_cyc);
      chk("illegal", illegal, cyc == ill_cyc);
      chk("flags",   flags, flags_m);
      chk("rd_data", rd_data, regs_m[rd_addr]);
`ifdef OVF_TRAP_EN
      chk("trap",    trap, cyc == trap_cyc);
`endif
      if (busy_m && cyc == acc_cyc) begin
        chk("opcode", alu_opcode, op_m);
        chk("alu_a",  alu_a, a_m);
        chk("alu_b",  alu_b, b_m);
      end
      if (alu_en) en_cnt++;
      if (done) begin done_cnt++; obs_done_cyc = cyc; end
      if (illegal) ill_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
    rd_addr = rd_addr + 2'd1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Offer an instruction until accepted; returns the accept cycle.
  task automatic send(input logic [9:0] ins, input bit keep, output int acc);
    bit ok;
    ok = 1'b0; acc = -1;
    instr = ins; instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin
        step(); acc = cyc; ok = 1'b1;
        break;
      end
      step();
    end
    if (!keep) instr_valid = 1'b0;
    if (!ok) begin bad++; total++; $display("FAIL accept_timeout: got none expected accept"); end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (instr_ready) begin ok = 1'b1; break; end
    end
    step();
    if (!ok) begin bad++; total++; $display("FAIL idle_timeout: got busy expected ready"); end
  endtask

  task automatic rchk(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_addr = a; #1;
    chk(nm, rd_data, exp);
  endtask

  int acc1, acc2;
  logic [9:0] seq [8] = '{10'b0100_10_00_01, 10'b0101_11_00_01, 10'b0110_10_00_01,
                          10'b0111_11_00_11, 10'b0000_01_00_00, 10'b0001_01_00_00,
                          10'b1111_01_00_00, 10'b0011_01_00_01};

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) rchk(i[1:0], 8'h00, "reset_reg");
    chk("reset_flags", flags, 4'b0000);
    chk("reset_ready", instr_ready, 1'b1);

    // 1: ADD R2,R0,R1 with 2+3
    wr(2'd0, 8'd2); wr(2'd1, 8'd3);
    send(10'b0010_10_00_01, 1'b0, acc1);
    wait_idle();
    rchk(2'd2, 8'd5, "t1_r2");
    chk("t1_flags", flags, 4'b0000);
    chk("t1_en_pulses", en_cnt, 1);
    chk("t1_latency", obs_done_cyc - acc1, LAT + 2);

    // 2: SUB R3,R0,R0 with R0=40
    wr(2'd0, 8'd40);
    send(10'b0011_11_00_00, 1'b0, acc1);
    wait_idle();
    rchk(2'd3, 8'd0, "t2_r3");
    chk("t2_flags", flags, 4'b0001);

    // 3: 80+80 overflows
    wr(2'd0, 8'd80); wr(2'd1, 8'd80);
    send(10'b0010_10_00_01, 1'b0, acc1);
    wait_idle();
`ifdef OVF_TRAP_EN
    rchk(2'd2, 8'h05, "t3_r2");
`else
    rchk(2'd2, 8'hA0, "t3_r2");
`endif
    chk("t3_flags", flags, 4'b0110);

    // 4: illegal opcode
    send(10'b1000_00_00_00, 1'b0, acc1);
    wait_idle();
    chk("t4_illegal_pulses", ill_cnt, 1);
    chk("t4_en_pulses", en_cnt, 3);
    rchk(2'd0, 8'd80, "t4_r0");

    // 5: host write to R2 in the WB cycle of ADD R2 (3+4)
    wr(2'd0, 8'd3); wr(2'd1, 8'd4);
    send(10'b0010_10_00_01, 1'b0, acc1);
    repeat (LAT + 1) step();
    wr(2'd2, 8'h55);
    wait_idle();
    rchk(2'd2, 8'h07, "t5_wb_wins");
    send(10'b0010_10_00_01, 1'b0, acc1);
    repeat (LAT + 1) step();
    wr(2'd1, 8'h99);
    wait_idle();
    rchk(2'd2, 8'h07, "t5_r2");
    rchk(2'd1, 8'h99, "t5_r1");
    // write to RA during WAIT does not touch the in-flight op
    send(10'b0010_10_00_01, 1'b0, acc1);
    wr(2'd0, 8'h10);
    wait_idle();
    rchk(2'd2, 8'h9C, "t5_wait_wr_r2");
    rchk(2'd0, 8'h10, "t5_wait_wr_r0");

    // logic ops and a few illegal opcodes
    wr(2'd0, 8'hF0); wr(2'd1, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      send(seq[i], 1'b0, acc1);
      wait_idle();
    end
    rchk(2'd2, 8'hCC, "xor_r2");
    rchk(2'd3, 8'h0F, "not_r3");
    chk("illegal_total", ill_cnt, 4);

    // 6: reset during WAIT
    acc2 = done_cnt;
    send(10'b0010_10_00_01, 1'b0, acc1);
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("t6_no_done", done_cnt, acc2);
    for (int i = 0; i < 4; i++) rchk(i[1:0], 8'h00, "t6_reg");
    chk("t6_flags", flags, 4'b0000);
    chk("t6_ready", instr_ready, 1'b1);

    // back-to-back: second instruction held valid while busy
    wr(2'd0, 8'd1); wr(2'd1, 8'd2);
    send(10'b0010_10_00_01, 1'b1, acc1);
    send(10'b0101_11_00_01, 1'b0, acc2);
    wait_idle();
    chk("b2b_spacing", acc2 - acc1, LAT + 3);
    rchk(2'd2, 8'd3, "b2b_r2");
    rchk(2'd3, 8'd3, "b2b_r3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
